// File: rtl/nap_alarm_ctrl.sv
// Nap alarm controller: schedules a wake time through an external BCD adder,
// normalises it to 24-hour time, rings on an exact match and handles
// stop / snooze / ring timeout.
module nap_alarm_ctrl #(
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned MAX_SNOOZE = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1s,
   input  logic [23:0] cur_time,
   input  logic [23:0] nap_time,
   input  logic        start,
   input  logic        stop,
   input  logic        snooze,
   output logic [23:0] add_a,
   output logic [23:0] add_b,
   input  logic [23:0] add_sum,
   output logic [23:0] wake_time,
   output logic [1:0]  state,
   output logic        alarm,
   output logic [3:0]  snooze_cnt,
   output logic        missed,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ARMED = 2'd2,
      ST_RING  = 2'd3
   } state_t;

   localparam logic [23:0] SNOOZE_BCD = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};
   localparam logic [7:0]  RING_LAST  = 8'(RING_SEC - 1);
   localparam logic [3:0]  SNOOZE_MAX = 4'(MAX_SNOOZE);

   state_t      state_q, state_d;
   logic [23:0] add_a_q, add_a_d;
   logic [23:0] add_b_q, add_b_d;
   logic [23:0] wake_time_q, wake_time_d;
   logic [3:0]  snooze_cnt_q, snooze_cnt_d;
   logic        missed_q, missed_d;
   logic        err_q, err_d;
   logic [7:0]  ring_cnt_q, ring_cnt_d;

   logic        nap_ok;
   logic [7:0]  hbin;
   logic [7:0]  hadj;
   logic [3:0]  h10n;
   logic [3:0]  h1n;
   logic [23:0] norm_sum;

   // Nap duration validity: legal BCD digits, minutes/seconds < 60, hours < 24, non-zero
   always_comb begin
      nap_ok = (nap_time[19:16] <= 4'd9) &&
               (nap_time[15:12] <= 4'd5) &&
               (nap_time[11:8]  <= 4'd9) &&
               (nap_time[7:4]   <= 4'd5) &&
               (nap_time[3:0]   <= 4'd9) &&
               ((nap_time[23:20] < 4'd2) ||
                ((nap_time[23:20] == 4'd2) && (nap_time[19:16] <= 4'd3))) &&
               (nap_time != '0);
   end

   // Fold the unwrapped adder hour field (0..47) back into 0..23 and re-encode as BCD
   always_comb begin
      hbin = ({4'b0, add_sum[23:20]} * 8'd10) + {4'b0, add_sum[19:16]};
      hadj = (hbin >= 8'd24) ? (hbin - 8'd24) : hbin;
      h10n = 4'd0;
      h1n  = hadj[3:0];
      if (hadj >= 8'd20) begin
         h10n = 4'd2;
         h1n  = 4'(hadj - 8'd20);
      end else if (hadj >= 8'd10) begin
         h10n = 4'd1;
         h1n  = 4'(hadj - 8'd10);
      end
      norm_sum = {h10n, h1n, add_sum[15:0]};
   end

   // Next-state and register updates; stop outranks snooze outranks start/timeout
   always_comb begin
      state_d      = state_q;
      add_a_d      = add_a_q;
      add_b_d      = add_b_q;
      wake_time_d  = wake_time_q;
      snooze_cnt_d = snooze_cnt_q;
      missed_d     = missed_q;
      ring_cnt_d   = ring_cnt_q;
      err_d        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               if (nap_ok) begin
                  add_a_d      = cur_time;
                  add_b_d      = nap_time;
                  snooze_cnt_d = '0;
                  missed_d     = 1'b0;
                  state_d      = ST_CALC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_CALC: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else begin
               wake_time_d = norm_sum;
               state_d     = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               if (nap_ok) begin
                  add_a_d      = cur_time;
                  add_b_d      = nap_time;
                  snooze_cnt_d = '0;
                  missed_d     = 1'b0;
                  state_d      = ST_CALC;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cur_time == wake_time_q) begin
               ring_cnt_d = '0;
               state_d    = ST_RING;
            end
         end
         ST_RING: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (snooze && (snooze_cnt_q < SNOOZE_MAX)) begin
               add_a_d      = cur_time;
               add_b_d      = SNOOZE_BCD;
               snooze_cnt_d = snooze_cnt_q + 4'd1;
               state_d      = ST_CALC;
            end else if (tick_1s) begin
               ring_cnt_d = ring_cnt_q + 8'd1;
               if (ring_cnt_q == RING_LAST) begin
                  missed_d = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         add_a_q      <= '0;
         add_b_q      <= '0;
         wake_time_q  <= '0;
         snooze_cnt_q <= '0;
         missed_q     <= 1'b0;
         err_q        <= 1'b0;
         ring_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         add_a_q      <= add_a_d;
         add_b_q      <= add_b_d;
         wake_time_q  <= wake_time_d;
         snooze_cnt_q <= snooze_cnt_d;
         missed_q     <= missed_d;
         err_q        <= err_d;
         ring_cnt_q   <= ring_cnt_d;
      end
   end

   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign wake_time  = wake_time_q;
   assign state      = state_q;
   assign alarm      = (state_q == ST_RING);
   assign snooze_cnt = snooze_cnt_q;
   assign missed     = missed_q;
   assign err        = err_q;

endmodule

// File: tb/tb_nap_alarm_ctrl.sv
// Scoreboard bench for nap_alarm_ctrl: a seconds-based reference model predicts
// every output each cycle; a monitor pops and compares after each clock edge.
module tb_nap_alarm_ctrl;

   localparam int SNOOZE_MIN = 5;
   localparam int RING_SEC   = 60;
   localparam int MAX_SNOOZE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1s = 1'b0;
   logic [23:0] cur_time = '0;
   logic [23:0] nap_time = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        snooze = 1'b0;
   logic [23:0] add_a, add_b, add_sum, wake_time;
   logic [1:0]  state;
   logic        alarm, missed, err;
   logic [3:0]  snooze_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nap_alarm_ctrl #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_SEC  (RING_SEC),
      .MAX_SNOOZE(MAX_SNOOZE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_1s   (tick_1s),
      .cur_time  (cur_time),
      .nap_time  (nap_time),
      .start     (start),
      .stop      (stop),
      .snooze    (snooze),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .wake_time (wake_time),
      .state     (state),
      .alarm     (alarm),
      .snooze_cnt(snooze_cnt),
      .missed    (missed),
      .err       (err)
   );

   function automatic int to_sec(input logic [23:0] b);
      return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
             (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
             (int'(b[7:4]) * 10 + int'(b[3:0]));
   endfunction

   // Hours are not wrapped, so this also serves as the external adder
   function automatic logic [23:0] to_bcd(input int secs);
      int h, m, s;
      h = secs / 3600;
      m = (secs / 60) % 60;
      s = secs % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic bit dur_valid(input logic [23:0] b);
      bit ok;
      ok = (b[19:16] <= 9) && (b[11:8] <= 9) && (b[3:0] <= 9) &&
           (b[15:12] <= 5) && (b[7:4] <= 5) &&
           (int'(b[23:20]) * 10 + int'(b[19:16]) <= 23) && (b != 24'h0);
      return ok;
   endfunction

   assign add_sum = to_bcd(to_sec(add_a) + to_sec(add_b));

   // Reference model state
   int          m_state = 0;
   logic [23:0] m_a = '0, m_b = '0, m_wake = '0;
   int          m_scnt = 0, m_ring = 0;
   bit          m_missed = 0, m_err = 0;

   typedef struct packed {
      logic [1:0]  st;
      logic        alarm;
      logic [23:0] wake;
      logic [3:0]  scnt;
      logic        missed;
      logic        err;
      logic [23:0] a;
      logic [23:0] b;
   } snap_t;

   snap_t exp_q[$];

   task automatic schedule(input logic [23:0] cur, input logic [23:0] nap);
      if (dur_valid(nap)) begin
         m_a = cur; m_b = nap; m_scnt = 0; m_missed = 0; m_state = 1;
      end else begin
         m_err = 1;
      end
   endtask

   task automatic model_step(input bit r, input bit st, input bit sp, input bit sn,
                             input bit tk, input logic [23:0] cur, input logic [23:0] nap);
      m_err = 0;
      if (r) begin
         m_state = 0; m_a = '0; m_b = '0; m_wake = '0;
         m_scnt = 0; m_ring = 0; m_missed = 0;
         return;
      end
      case (m_state)
         0: if (!sp && st) schedule(cur, nap);
         1: begin
            if (sp) m_state = 0;
            else begin
               m_wake  = to_bcd((to_sec(m_a) + to_sec(m_b)) % 86400);
               m_state = 2;
            end
         end
         2: begin
            if (sp) m_state = 0;
            else if (st) schedule(cur, nap);
            else if (cur == m_wake) begin m_state = 3; m_ring = 0; end
         end
         default: begin
            if (sp) m_state = 0;
            else if (sn && m_scnt < MAX_SNOOZE) begin
               m_a = cur; m_b = to_bcd(SNOOZE_MIN * 60); m_scnt++; m_state = 1;
            end else if (tk) begin
               m_ring++;
               if (m_ring == RING_SEC) begin m_state = 0; m_missed = 1; end
            end
         end
      endcase
   endtask

   // One clock of stimulus: drive at the falling edge, predict, enqueue expectation
   task automatic cyc(input bit r, input bit st, input bit sp, input bit sn, input bit tk,
                      input logic [23:0] cur, input logic [23:0] nap);
      snap_t e;
      @(negedge clk);
      rst = r; start = st; stop = sp; snooze = sn; tick_1s = tk;
      cur_time = cur; nap_time = nap;
      model_step(r, st, sp, sn, tk, cur, nap);
      e.st = 2'(m_state); e.alarm = (m_state == 3); e.wake = m_wake;
      e.scnt = 4'(m_scnt); e.missed = m_missed; e.err = m_err; e.a = m_a; e.b = m_b;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare DUT against each queued expectation just after the clock edge
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("alarm", 32'(alarm), 32'(e.alarm));
            chk("wake_time", 32'(wake_time), 32'(e.wake));
            chk("snooze_cnt", 32'(snooze_cnt), 32'(e.scnt));
            chk("missed", 32'(missed), 32'(e.missed));
            chk("err", 32'(err), 32'(e.err));
            chk("add_a", 32'(add_a), 32'(e.a));
            chk("add_b", 32'(add_b), 32'(e.b));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] wk [3];
      logic [23:0] c, n;
      bit st, sp, sn, tk, r;
      wk[0] = 24'h070500; wk[1] = 24'h071000; wk[2] = 24'h071500;

      // reset
      cyc(1, 0, 0, 0, 0, '0, '0);
      cyc(1, 0, 0, 0, 0, '0, '0);
      settle();
      chk("reset_state", 32'(state), 0);

      // midnight wrap
      cyc(0, 1, 0, 0, 0, 24'h235030, 24'h002045);
      settle(); chk("wrap_calc_state", 32'(state), 1);
      cyc(0, 0, 0, 0, 0, 24'h235030, 24'h002045);
      settle(); chk("wrap_armed_state", 32'(state), 2);
      chk("wrap_wake", 32'(wake_time), 32'h001115);

      // ring and stop
      cyc(0, 0, 0, 0, 0, 24'h001115, '0);
      settle(); chk("ring_alarm", 32'(alarm), 1);
      cyc(0, 0, 1, 0, 0, 24'h001115, '0);
      settle(); chk("stop_alarm", 32'(alarm), 0); chk("stop_missed", 32'(missed), 0);

      // snooze up to the limit
      cyc(0, 1, 0, 0, 0, 24'h065900, 24'h000100);
      cyc(0, 0, 0, 0, 0, 24'h065900, 24'h000100);
      c = 24'h070000;
      cyc(0, 0, 0, 0, 0, c, '0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 0, c, '0);
         cyc(0, 0, 0, 0, 0, c, '0);
         settle();
         chk("snooze_wake", 32'(wake_time), 32'(wk[k]));
         chk("snooze_cnt_step", 32'(snooze_cnt), 32'(k + 1));
         c = wk[k];
         cyc(0, 0, 0, 0, 0, c, '0);
      end
      cyc(0, 0, 0, 1, 0, c, '0);
      settle(); chk("snooze_limit_alarm", 32'(alarm), 1);
      cyc(0, 0, 1, 1, 0, c, '0);
      settle(); chk("stop_snooze_state", 32'(state), 0);
      chk("stop_snooze_cnt", 32'(snooze_cnt), 3);

      // ring timeout
      cyc(0, 1, 0, 0, 0, 24'h100000, 24'h000001);
      cyc(0, 0, 0, 0, 0, 24'h100000, '0);
      cyc(0, 0, 0, 0, 0, 24'h100001, '0);
      for (int k = 0; k < RING_SEC; k++) cyc(0, 0, 0, 0, 1, 24'h100001, '0);
      settle(); chk("timeout_state", 32'(state), 0); chk("timeout_missed", 32'(missed), 1);
      cyc(0, 1, 0, 0, 0, 24'h100001, 24'h000100);
      settle(); chk("restart_missed", 32'(missed), 0);
      cyc(0, 0, 1, 0, 0, 24'h100001, '0);

      // rejects
      cyc(0, 1, 0, 0, 0, 24'h120000, 24'h006000);
      settle(); chk("rej60_err", 32'(err), 1); chk("rej60_state", 32'(state), 0);
      cyc(0, 1, 0, 0, 0, 24'h120000, 24'h000000);
      settle(); chk("rej0_err", 32'(err), 1);
      cyc(0, 0, 0, 0, 0, 24'h120000, '0);

      // reset mid-CALC
      cyc(0, 1, 0, 0, 0, 24'h120000, 24'h000500);
      settle(); chk("rstcalc_pre", 32'(state), 1);
      cyc(1, 0, 0, 0, 0, 24'h120000, '0);
      settle(); chk("rstcalc_state", 32'(state), 0); chk("rstcalc_wake", 32'(wake_time), 0);
      chk("rstcalc_add_a", 32'(add_a), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(299) == 0);
         tk = ($urandom_range(2) == 0);
         sp = ($urandom_range(19) == 0);
         sn = ($urandom_range(5) == 0);
         st = ($urandom_range(7) == 0);
         if ($urandom_range(1) == 0) n = to_bcd($urandom_range(86399, 1));
         else n = 24'($urandom());
         if (m_state == 2 && $urandom_range(3) == 0) c = m_wake;
         else if ($urandom_range(3) == 0) c = to_bcd($urandom_range(86399));
         if (sn) begin st = 0; tk = 0; end
         if (m_state == 2 && c == m_wake) st = 0;
         cyc(r, st, sp, sn, tk, c, n);
      end
      cyc(0, 0, 1, 0, 0, c, '0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nap_alarm_ctrl.md
Name: nap_alarm_ctrl

Overview:
- Sequences the BCD time adder for the nap alarm: captures current time plus the nap duration, and launches one add through the external adder.
- Normalises the raw sum to 24-hour time, arms, and compares against the running clock.
- Drives the alarm, handles stop/snooze, and reuses the same adder for snooze re-scheduling.
- Sits between the clock/keypad logic and the buzzer/display logic.

Parameters:
- SNOOZE_MIN, 5, snooze length in minutes (1..59); converted internally to a BCD duration of 00:MM:00.
- RING_SEC, 60, seconds the alarm rings before auto-timeout (1..255).
- MAX_SNOOZE, 3, maximum snoozes per nap (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- tick_1s  in  1  one-clk pulse once per second.
- cur_time  in  24  current time, BCD {H10,H1,M10,M1,S10,S1}, 4 bits each.
- nap_time  in  24  nap duration, same BCD packing.
- start  in  1  level sampled each clk; request to schedule a nap.
- stop  in  1  cancel or acknowledge.
- snooze  in  1  snooze request.
- add_a  out  24  adder operand A (registered).
- add_b  out  24  adder operand B (registered).
- add_sum  in  24  adder result, combinational from add_a/add_b; hour field unwrapped.
- wake_time  out  24  normalised wake time (registered).
- state  out  2  0=IDLE, 1=CALC, 2=ARMED, 3=RING.
- alarm  out  1  high while in RING.
- snooze_cnt  out  4  snoozes used this nap.
- missed  out  1  sticky: ring timed out.
- err  out  1  one-clk pulse: start rejected.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Input priority in any cycle: stop > snooze > start.
- Valid duration (checked for nap_time):
  - every digit ≤9; M10 and S10 ≤5; hours ≤23; not all zero.
- IDLE:
  - start with valid nap_time: add_a<=cur_time, add_b<=nap_time, snooze_cnt<=0, missed<=0, go to CALC.
  - start with invalid nap_time: err=1 for one clk, stay in IDLE.
- CALC (exactly one clk):
  - add_sum is sampled at the end of the cycle.
  - Let H = 10*H10 + H1 of add_sum. If H ≥24, hours := H−24 re-encoded as BCD; minutes and seconds pass through unchanged.
  - wake_time <= normalised result; go to ARMED.
  - Latency: start sampled at cycle N → CALC at N+1 → ARMED with wake_time valid at N+2.
  - stop during CALC: go to IDLE and discard the result.
- ARMED:
  - cur_time == wake_time (full 24-bit compare, every clk): go to RING, ring_cnt<=0.
  - stop: go to IDLE; wake_time is held.
  - start: re-schedule from the current cur_time (same as the IDLE path, including validity/err).
  - snooze: ignored.
- RING:
  - alarm=1.
  - ring_cnt increments on each tick_1s.
  - ring_cnt reaching RING_SEC: go to IDLE, missed<=1.
  - stop: go to IDLE.
  - snooze with snooze_cnt < MAX_SNOOZE: add_a<=cur_time, add_b<=BCD(00:SNOOZE_MIN:00), snooze_cnt++, go to CALC.
  - snooze with snooze_cnt == MAX_SNOOZE: ignored; keep ringing.
  - start: ignored.
- Outside IDLE/ARMED-start and RING-snooze, add_a and add_b hold their last values.
- Adder contract: add_sum must be settled within one clk of an operand change. The controller never samples add_sum in the cycle the operands are written.
- Midnight wrap: raw sums of 24..47 hours are normalised; the sum is never ≥48 because both operand hour fields are ≤23 and the carry-in from minutes is ≤1.
- rst mid-operation: immediate return to IDLE, alarm=0, all registers cleared on that clk.
- A cur_time jump past wake_time while ARMED does not trigger; only exact equality rings.

Test Plan:
- Midnight wrap: cur=23:50:30, nap=00:20:45, start pulse → state 1 next clk, then state 2 with wake_time=00:11:15. Raw add_sum=24:11:15 must be normalised.
- Ring and stop: after arming wake=00:11:15, drive cur_time to 00:11:15 → alarm=1 next clk; stop pulse → alarm=0, state=0, missed=0.
- Snooze limit: in RING at cur=07:00:00, snooze → wake_time=07:05:00, snooze_cnt=1.
  - Repeat 3 times total; the 4th snooze is ignored and alarm stays 1.
- Timeout: RING with RING_SEC=60; 60 tick_1s pulses, no stop → state=0, alarm=0, missed=1. The next valid start clears missed.
- Rejects and priority:
  - nap=00:60:00 → err pulse, state stays 0.
  - nap=00:00:00 → err pulse.
  - stop and snooze in the same clk during RING → IDLE, snooze_cnt unchanged.
- Reset mid-CALC: assert rst while state=1 → next clk all outputs 0, state=0, wake_time=0.
